mc6809_irqc: RTL
================

# mc6809_irqc

Memory-mapped interrupt controller that responds on the MC6809 bus and drives the CPU's interrupt inputs. It collects 8 peripheral interrupt sources, raises nIRQ/nFIRQ, and answers the CPU's vector fetches (BS=1, BA=0) with a per-source ISR address. It sits beside the CPU core on the system bus and is the responder end of the core's interrupt request/acknowledge protocol.

## Interface
- BASE_ADDR, 16'hFF80, base of the 4-byte register window (must be 4-aligned).
- VEC_BASE, 16'hFE00, ISR address of source 0; source i uses VEC_BASE + 16*i.
- SPUR_VEC, 16'hFE80, ISR address returned when no eligible source is pending.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  16  CPU address.
- RnW  in  1  1 = read, 0 = write.
- VMA  in  1  current bus cycle is valid.
- BS, BA  in  1 each  CPU bus status; BS=1 with BA=0 marks a vector fetch.
- DIN  in  8  CPU write data.
- DOUT  out  8  read data; 0 whenever DOE=0.
- DOE  out  1  responder drives the data bus this cycle.
- SRC  in  8  interrupt sources, synchronous to CLK, active-high.
- nIRQ, nFIRQ  out  1 each  active-low interrupt requests, registered.
- INTVEC  out  16  registered ISR address of the current highest-priority IRQ-class source, or SPUR_VEC.

## Operation
- Registers at BASE_ADDR offsets: +0 PEND (read; write 1 clears bits), +1 MASK (R/W), +2 FSEL (R/W; 1 routes source to FIRQ), +3 EDGE (R/W; 1 = rising-edge source, 0 = level source).
- Access qualifier: VMA=1 and ADDR in window. Reads use combinational DOUT, DOE=1. Writes use DIN and take effect at the next edge.
- Edge source: pending sets on SRC & ~SRC_Q, clears by W1C or auto-ack. If set and clear land in the same cycle, set wins.
- Level source: PEND bit = SRC_Q every cycle. W1C has no effect.
- SRC_Q: registered SRC. During RESET, SRC_Q loads SRC, so a source already high at reset release gives no edge.
- Eligible IRQ = PEND & MASK & ~FSEL. Eligible FIRQ = PEND & MASK & FSEL. Lowest index has highest priority.
- nIRQ = ~|eligible IRQ; nFIRQ = ~|eligible FIRQ. Both registered.
- Vector fetch is VMA & RnW & BS & ~BA.
  - ADDR=FFF8 (IRQ) or FFF6 (FIRQ): latch the class's winning index, or a spurious flag if none. DOUT = ISR[15:8], DOE=1.
  - ADDR=FFF9 or FFF7: DOUT = ISR[7:0] from the latched index, so both bytes are consistent even if PEND changes between them. DOE=1.
  - At the same edge, if the latched source is edge mode, its PEND bit auto-clears.
  - A low-byte fetch without a prior high-byte latch uses the latch contents as-is.
- Fetches to other vector addresses: DOE=0.

## Timing
- Reset values: PEND, MASK, FSEL, EDGE, latch = 0; spurious flag = 1; nIRQ = nFIRQ = 1; INTVEC = SPUR_VEC; DOE = 0; DOUT = 0.
- Edge on SRC at edge n gives PEND set at n+1 and nIRQ low at n+2.
- W1C or auto-ack at edge n gives nIRQ high at n+1 if nothing else is eligible.
- MASK/FSEL write at edge n is reflected on nIRQ/nFIRQ at n+1.
- Read data is valid in the same cycle as the address; no wait states.
- RESET asserted mid-fetch aborts it: the latch returns to its reset values and DOE drops.

## Configuration
- MC6809_IRQC_FIRQ_EN defined: FSEL is implemented, nFIRQ is driven, and FFF6/FFF7 fetches are decoded.
- Not defined:
  - FSEL reads 0 and ignores writes, so all sources are IRQ class.
  - nFIRQ is tied to 1.
  - FFF6/FFF7 fetches give DOE=0.

## Structure
- Shared package mc6809_pkg: register offset constants, vector address constants (FFF6–FFF9), and the ISR address computation function.
- Sub-module mc6809_prio_enc8 (8-bit lowest-index-first priority encoder with valid output), instanced once per class.

## Test plan
- Reset, then read window → PEND/MASK/FSEL/EDGE = 00; nIRQ = nFIRQ = 1; INTVEC = FE80.
- EDGE=01, MASK=01, pulse SRC[0] → PEND=01, nIRQ low two edges after the pulse. Fetch FFF8/FFF9 → DOUT FE, 00; PEND=00 after FFF9; nIRQ high next cycle.
- SRC[3] and SRC[5] edge-pending, both masked → fetch returns FE30. Then SRC[1] rises between FFF8 and FFF9 → FFF9 still returns 30.
- Level source SRC[2] held high, write PEND=04 → PEND stays 04. Drop SRC[2] → PEND clears next edge.
- FSEL=80, MASK=80, edge SRC[7] → nFIRQ low and nIRQ high. Fetch FFF6/FFF7 → FE, 70. Without macro: nIRQ low and FFF6 gives DOE=0.
- W1C on PEND bit 0 in the same cycle as a new SRC[0] edge → PEND bit 0 remains set. RESET during FFF8/FFF9 → DOE=0, latch cleared.

Source files
------------

// File: rtl/mc6809_pkg.sv
// Shared constants and helpers for the MC6809 interrupt controller.
// Register offsets, vector fetch addresses and ISR address computation.
package mc6809_pkg;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_FSEL = 2'd2;
  localparam logic [1:0] OFF_EDGE = 2'd3;

  localparam logic [15:0] VEC_FIRQ_HI = 16'hFFF6;
  localparam logic [15:0] VEC_FIRQ_LO = 16'hFFF7;
  localparam logic [15:0] VEC_IRQ_HI  = 16'hFFF8;
  localparam logic [15:0] VEC_IRQ_LO  = 16'hFFF9;

  function automatic logic [15:0] isr_addr(
    input logic [15:0] vec_base,
    input logic [15:0] spur_vec,
    input logic [2:0]  idx,
    input logic        spur
  );
    isr_addr = spur ? spur_vec
                    : vec_base + {9'd0, idx, 4'd0};
  endfunction

endpackage

// File: rtl/mc6809_prio_enc8.sv
// 8-bit priority encoder, lowest set index wins.
// valid is high when any request bit is set.
module mc6809_prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mc6809_irqc.sv
// MC6809 bus interrupt controller: 8 sources, IRQ/FIRQ, vector fetch.
// Define MC6809_IRQC_FIRQ_EN to implement FSEL, nFIRQ and FFF6/FFF7.
module mc6809_irqc
  import mc6809_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF80,
  parameter logic [15:0] VEC_BASE  = 16'hFE00,
  parameter logic [15:0] SPUR_VEC  = 16'hFE80
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic        RnW,
  input  logic        VMA,
  input  logic        BS,
  input  logic        BA,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        DOE,
  input  logic [7:0]  SRC,
  output logic        nIRQ,
  output logic        nFIRQ,
  output logic [15:0] INTVEC
);

`ifdef MC6809_IRQC_FIRQ_EN
  localparam logic FIRQ_EN = 1'b1;
`else
  localparam logic FIRQ_EN = 1'b0;
`endif

  logic [7:0]  src_q, pend_q, mask_q, fsel_q, edge_q;
  logic [7:0]  pend_d, mask_d, fsel_d;
  logic [7:0]  edge_d;
  logic        nirq_q, nirq_d, nfirq_q, nfirq_d;
  logic [15:0] intvec_q, intvec_d;
  logic [2:0]  lidx_q, lidx_d;
  logic        lspur_q, lspur_d;

  logic        hit, rd, wr, vf;
  logic        hi_irq, lo_irq, hi_firq, lo_firq;
  logic [7:0]  irq_req, firq_req, clr;
  logic [2:0]  irq_idx, firq_idx;
  logic        irq_vld, firq_vld;
  logic [15:0] irq_isr, firq_isr, lat_isr;

  assign irq_req  = pend_q & mask_q & ~fsel_q;
  assign firq_req = pend_q & mask_q & fsel_q;

  mc6809_prio_enc8 u_enc_irq (
    .req   (irq_req),
    .idx   (irq_idx),
    .valid (irq_vld)
  );

  mc6809_prio_enc8 u_enc_firq (
    .req   (firq_req),
    .idx   (firq_idx),
    .valid (firq_vld)
  );

  assign irq_isr  = isr_addr(VEC_BASE, SPUR_VEC,
                             irq_idx, ~irq_vld);
  assign firq_isr = isr_addr(VEC_BASE, SPUR_VEC,
                             firq_idx, ~firq_vld);
  assign lat_isr  = isr_addr(VEC_BASE, SPUR_VEC,
                             lidx_q, lspur_q);

  assign hit = VMA && (ADDR[15:2] == BASE_ADDR[15:2]);
  assign rd  = hit && RnW;
  assign wr  = hit && !RnW;
  assign vf  = VMA && RnW && BS && !BA;

  assign hi_irq  = vf && (ADDR == VEC_IRQ_HI);
  assign lo_irq  = vf && (ADDR == VEC_IRQ_LO);
  assign hi_firq = FIRQ_EN && vf && (ADDR == VEC_FIRQ_HI);
  assign lo_firq = FIRQ_EN && vf && (ADDR == VEC_FIRQ_LO);

  always_comb begin
    mask_d  = mask_q;
    fsel_d  = fsel_q;
    edge_d  = edge_q;
    lidx_d  = lidx_q;
    lspur_d = lspur_q;
    clr     = '0;
    if (wr) begin
      unique case (ADDR[1:0])
        OFF_PEND: clr    = DIN;
        OFF_MASK: mask_d = DIN;
        OFF_FSEL: if (FIRQ_EN) fsel_d = DIN;
        OFF_EDGE: edge_d = DIN;
        default:  ;
      endcase
    end
    if (hi_irq) begin
      lidx_d  = irq_idx;
      lspur_d = ~irq_vld;
    end
    if (hi_firq) begin
      lidx_d  = firq_idx;
      lspur_d = ~firq_vld;
    end
    // Low-byte fetch acknowledges the latched source.
    if ((lo_irq || lo_firq) && !lspur_q)
      clr[lidx_q] = 1'b1;
    // Edge bits: set beats clear. Level bits track SRC.
    pend_d = (edge_q & ((pend_q & ~clr) | (SRC & ~src_q)))
           | (~edge_q & SRC);
    nirq_d   = ~irq_vld;
    nfirq_d  = ~(FIRQ_EN && firq_vld);
    intvec_d = irq_isr;
  end

  always_comb begin
    DOUT = '0;
    DOE  = 1'b0;
    if (!RESET) begin
      unique case (1'b1)
        rd: begin
          DOE = 1'b1;
          unique case (ADDR[1:0])
            OFF_PEND: DOUT = pend_q;
            OFF_MASK: DOUT = mask_q;
            OFF_FSEL: DOUT = fsel_q;
            OFF_EDGE: DOUT = edge_q;
            default:  DOUT = '0;
          endcase
        end
        hi_irq: begin
          DOE  = 1'b1;
          DOUT = irq_isr[15:8];
        end
        hi_firq: begin
          DOE  = 1'b1;
          DOUT = firq_isr[15:8];
        end
        (lo_irq || lo_firq): begin
          DOE  = 1'b1;
          DOUT = lat_isr[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      src_q    <= SRC;
      pend_q   <= '0;
      mask_q   <= '0;
      fsel_q   <= '0;
      edge_q   <= '0;
      nirq_q   <= 1'b1;
      nfirq_q  <= 1'b1;
      intvec_q <= SPUR_VEC;
      lidx_q   <= '0;
      lspur_q  <= 1'b1;
    end else begin
      src_q    <= SRC;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      fsel_q   <= fsel_d;
      edge_q   <= edge_d;
      nirq_q   <= nirq_d;
      nfirq_q  <= nfirq_d;
      intvec_q <= intvec_d;
      lidx_q   <= lidx_d;
      lspur_q  <= lspur_d;
    end
  end

  assign nIRQ   = nirq_q;
  assign nFIRQ  = nfirq_q;
  assign INTVEC = intvec_q;

endmodule
